// File: rtl/fetch_unit_pkg.sv
// Shared bus types (common) and fetch-stage types (pipes) used by fetch_unit.
package common;
  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  typedef struct packed {
    logic valid;
    u64   addr;
  } ibus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u32   data;
  } ibus_resp_t;
endpackage

package pipes;
  typedef enum logic [1:0] {
    LAUNCH = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    DROP   = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one ibus request per PC, buffers the returned
// instruction for decode, and squashes responses of redirected fetches.
module fetch_unit
  import common::*;
  import pipes::*;
(
  input  logic       clk,
  input  logic       reset,
  input  u64         pc,
  input  logic       stall,
  input  logic       redirect,
  output ibus_req_t  ireq,
  input  ibus_resp_t iresp,
  output u32         instr,
  output u64         instr_pc,
  output logic       instr_valid,
  output logic       invalid
);

  fetch_state_t state_q, state_d;
  u32           instr_q, instr_d;
  u64           instr_pc_q, instr_pc_d;
  u64           req_addr_q, req_addr_d;

  // Completion is signalled by data_ok alone.
  logic unused_addr_ok;
  assign unused_addr_ok = iresp.addr_ok;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    req_addr_d = req_addr_q;
    ireq.valid = 1'b1;
    ireq.addr  = req_addr_q;

    unique case (state_q)
      LAUNCH: begin
        ireq.addr  = pc;
        req_addr_d = pc;
        if (redirect) begin
          state_d = iresp.data_ok ? LAUNCH : DROP;
        end else if (iresp.data_ok) begin
          instr_d    = iresp.data;
          instr_pc_d = pc;
          state_d    = HOLD;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_d = iresp.data_ok ? LAUNCH : DROP;
        end else if (iresp.data_ok) begin
          instr_d    = iresp.data;
          instr_pc_d = req_addr_q;
          state_d    = HOLD;
        end
      end
      DROP: begin
        // The squashed transaction must still complete before a new launch.
        if (iresp.data_ok) state_d = LAUNCH;
      end
      HOLD: begin
        ireq.valid = 1'b0;
        if (redirect || !stall) state_d = LAUNCH;
      end
      default: state_d = LAUNCH;
    endcase

    if (reset) ireq.valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LAUNCH;
      instr_q    <= '0;
      instr_pc_q <= '0;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = (state_q == HOLD) && !redirect;
  assign invalid     = (state_q != HOLD);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level reference model.
module tb_fetch_unit;
  import common::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  u64         pc = 64'h0;
  logic       stall = 1'b0;
  logic       redirect = 1'b0;
  ibus_req_t  ireq;
  ibus_resp_t iresp = '0;
  u32         instr;
  u64         instr_pc;
  logic       instr_valid;
  logic       invalid;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .pc(pc), .stall(stall), .redirect(redirect),
    .ireq(ireq), .iresp(iresp), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .invalid(invalid)
  );

  always #5 clk = ~clk;

  // Model: a fetch is either in flight (possibly squashed) or a buffered
  // instruction is waiting for decode; otherwise a new fetch launches from pc.
  bit m_busy, m_squash, m_have;
  u64 m_addr, m_ipc;
  u32 m_instr;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_squash = 0; m_have = 0;
      m_addr = 0; m_ipc = 0; m_instr = 0;
    end else if (m_have) begin
      if (redirect || !stall) m_have = 0;
    end else begin
      u64 a;
      a = m_busy ? m_addr : pc;
      if (iresp.data_ok) begin
        if (!redirect && !m_squash) begin
          m_have = 1; m_instr = iresp.data; m_ipc = a;
        end
        m_busy = 0; m_squash = 0;
      end else begin
        m_busy = 1; m_addr = a;
        m_squash = m_squash | redirect;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (reset) begin
        chk("model_valid_in_reset", 64'(ireq.valid), 64'd0);
      end else begin
        chk("model_valid", 64'(ireq.valid), 64'(!m_have));
        if (!m_have) chk("model_addr", ireq.addr, m_busy ? m_addr : pc);
        chk("model_instr_valid", 64'(instr_valid), 64'(m_have && !redirect));
        chk("model_invalid", 64'(invalid), 64'(!m_have));
        chk("model_instr", 64'(instr), 64'(m_instr));
        chk("model_instr_pc", instr_pc, m_ipc);
      end
    end
  end

  task automatic drive(input logic rst, input u64 p, input logic st, input logic rd,
                       input logic dok, input u32 d);
    reset = rst; pc = p; stall = st; redirect = rd;
    iresp.addr_ok = 1'b1; iresp.data_ok = dok; iresp.data = d;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    started = 1'b1;
    // Reset
    drive(1, 64'h8000_0000, 0, 0, 0, 0);
    chk("reset_valid", 64'(ireq.valid), 0);
    tick();
    drive(1, 64'h8000_0000, 0, 0, 0, 0);
    tick();

    // Single zero-wait fetch
    drive(0, 64'h8000_0000, 1, 0, 1, 32'h0000_0013);
    chk("rst_invalid", 64'(invalid), 1);
    chk("rst_instr_valid", 64'(instr_valid), 0);
    chk("rst_instr", 64'(instr), 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("launch_addr", ireq.addr, 64'h8000_0000);
    tick();
    drive(0, 64'h8000_0004, 1, 0, 0, 0);
    chk("first_iv", 64'(instr_valid), 1);
    chk("first_instr", 64'(instr), 64'h13);
    chk("first_ipc", instr_pc, 64'h8000_0000);
    chk("first_invalid", 64'(invalid), 0);

    // Stall hold for 4 cycles
    for (int i = 0; i < 4; i++) begin
      drive(0, 64'h8000_0004, 1, 0, 0, 0);
      chk("stall_valid", 64'(ireq.valid), 0);
      chk("stall_instr", 64'(instr), 64'h13);
      tick();
    end
    drive(0, 64'h8000_0004, 0, 0, 0, 0);
    tick();

    // 3-cycle latency, pc changes mid-flight
    drive(0, 64'h8000_0004, 0, 0, 0, 0);
    chk("lat_addr0", ireq.addr, 64'h8000_0004);
    tick();
    drive(0, 64'h8000_0008, 0, 0, 0, 0);
    chk("lat_addr1", ireq.addr, 64'h8000_0004);
    chk("lat_invalid1", 64'(invalid), 1);
    tick();
    drive(0, 64'h8000_0008, 0, 0, 1, 32'haaaa_0001);
    chk("lat_addr2", ireq.addr, 64'h8000_0004);
    tick();
    drive(0, 64'h8000_0008, 0, 0, 0, 0);
    chk("lat_iv", 64'(instr_valid), 1);
    chk("lat_instr", 64'(instr), 64'haaaa_0001);
    chk("lat_ipc", instr_pc, 64'h8000_0004);
    tick();

    // Redirect in WAIT: squashed fetch must never reach decode
    drive(0, 64'h8000_0008, 0, 0, 0, 0);
    tick();
    drive(0, 64'h8000_0100, 0, 1, 0, 0);
    tick();
    drive(0, 64'h8000_0100, 0, 0, 1, 32'hdead_beef);
    chk("drop_addr", ireq.addr, 64'h8000_0008);
    tick();
    drive(0, 64'h8000_0100, 1, 0, 1, 32'h0000_0100);
    chk("redir_iv", 64'(instr_valid), 0);
    chk("redir_addr", ireq.addr, 64'h8000_0100);
    tick();
    // Redirect while holding: decode must not see it
    drive(0, 64'h8000_0104, 1, 1, 0, 0);
    chk("hold_redir_iv", 64'(instr_valid), 0);
    chk("hold_redir_instr", 64'(instr), 64'h100);
    tick();

    // Redirect coincident with data_ok in the launch cycle
    drive(0, 64'h8000_0104, 0, 1, 1, 32'h1234_5678);
    tick();
    drive(0, 64'h8000_0200, 0, 0, 0, 0);
    chk("coinc_iv", 64'(instr_valid), 0);
    chk("coinc_addr", ireq.addr, 64'h8000_0200);
    chk("coinc_instr", 64'(instr), 64'h100);
    tick();

    // Reset during WAIT
    drive(1, 64'h8000_0400, 0, 0, 0, 0);
    chk("wait_rst_valid", 64'(ireq.valid), 0);
    tick();
    drive(0, 64'h8000_0400, 0, 0, 0, 0);
    chk("post_rst_addr", ireq.addr, 64'h8000_0400);
    chk("post_rst_instr", 64'(instr), 0);
    chk("post_rst_ipc", instr_pc, 0);
    chk("post_rst_invalid", 64'(invalid), 1);
    tick();
    drive(0, 64'h8000_0404, 0, 1, 0, 0);
    tick();
    drive(0, 64'h8000_0404, 0, 1, 0, 0);
    tick();
    drive(0, 64'h8000_0404, 0, 0, 1, 32'h5555_aaaa);
    tick();
    drive(0, 64'h8000_0404, 0, 0, 1, 32'h0000_0404);
    tick();
    drive(0, 64'h8000_0408, 0, 0, 0, 0);
    chk("final_ipc", instr_pc, 64'h8000_0404);
    chk("final_iv", 64'(instr_valid), 1);
    tick();
    drive(0, 64'h8000_0408, 0, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
